// File: rtl/echo_probe_pkg.sv
// Shared definitions for the UART echo probe: FSM encoding, error-count
// saturation limit and the timeout timer width.
package echo_probe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] ERR_SAT = 8'hFF;

  // Bits needed to hold 0 .. cycles-1; never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Per-byte wait timer: counts enabled cycles after a clear and flags the
// terminal count TIMEOUT_CYCLES-1.
module cycle_timer
  import echo_probe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned          W     = timer_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0]         LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/uart_echo_probe.sv
// Echo-loop initiator: sends an incrementing byte run through a UART,
// checks each echoed byte and reports verdict, error count and timeout.
module uart_echo_probe
  import echo_probe_pkg::*;
#(
  parameter int unsigned clk_freq       = 50000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [7:0] count,
  output logic       wr_uart,
  output logic [7:0] w_data,
  input  logic       tx_full,
  output logic       rd_uart,
  input  logic [7:0] r_data,
  input  logic       rx_empty,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] err_count,
  output logic [7:0] last_rx
);

  if (clk_freq == 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_echo_probe: clk_freq must be nonzero and TIMEOUT_CYCLES >= 2");
  end

  state_t     state, state_nx;
  logic [8:0] remaining;
  logic       timer_clr, timer_en, expired;

  cycle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_nx  = state;
    wr_uart   = 1'b0;
    rd_uart   = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_FLUSH;
      ST_FLUSH: begin
        if (!rx_empty) rd_uart  = 1'b1;
        else           state_nx = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_full) begin
          wr_uart   = 1'b1;
          timer_clr = 1'b1;
          state_nx  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Arriving data takes priority over an expiring timer.
        if (!rx_empty) begin
          rd_uart  = 1'b1;
          state_nx = (remaining == 9'd1) ? ST_DONE : ST_SEND;
        end else if (expired) begin
          state_nx = ST_DONE;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // w_data doubles as the expected-byte register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_count <= '0;
      last_rx   <= '0;
      w_data    <= '0;
      remaining <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != ST_IDLE);
      done  <= (state_nx == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            w_data    <= seed;
            remaining <= (count == 8'd0) ? 9'd256 : {1'b0, count};
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
          end
        end
        ST_WAIT: begin
          if (!rx_empty) begin
            last_rx   <= r_data;
            if (r_data != w_data && err_count != ERR_SAT)
              err_count <= err_count + 8'd1;
            w_data    <= w_data + 8'd1;
            remaining <= remaining - 9'd1;
          end else if (expired) begin
            timeout <= 1'b1;
            if (err_count != ERR_SAT) err_count <= err_count + 8'd1;
          end
        end
        ST_DONE: pass <= (err_count == 8'd0) && !timeout;
        default: ;
      endcase
    end
  end

endmodule
